alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameters SHALL be: RING_SECS, default 60, ring duration in seconds; SNOOZE_SECS, default 300, snooze duration in seconds.
REQ-002 fiveMhz  in  1  system clock; one clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 secTick  in  1  one-cycle pulse per second from timebase.
REQ-005 timeChange, alarmChange, alarmEnable  in  1 each  debounced switch levels.
REQ-006 minPress, hourPress  in  1 each  debounced one-cycle button pulses.
REQ-007 curHour  in  5  (0-23); curMin  in  6  (0-59); curSec  in  6  (0-59): running time.
REQ-008 alarmHour  in  5; alarmMin  in  6: stored alarm time.
REQ-009 timeMinInc, timeHourInc, alarmMinInc, alarmHourInc  out  1 each  one-cycle increment strobes to the time/alarm registers.
REQ-010 clockHold  out  1  freezes seconds counting while time is set.
REQ-011 alarmOn  out  1  flickering ring indicator; alarmEnabled  out  1  armed indicator; ringing  out  1  speaker/RGB gate; state  out  3  FSM state.

Function
REQ-012 FSM states SHALL be RUN, SET_TIME, SET_ALARM, RINGING, SNOOZE.
REQ-013 RUN->SET_TIME when timeChange=1; RUN->SET_ALARM when alarmChange=1 and timeChange=0 (timeChange wins if both).
REQ-014 SET_TIME->RUN and SET_ALARM->RUN when the respective switch drops; no cross transition between the two set states.
REQ-015 In SET_TIME, minPress/hourPress SHALL produce timeMinInc/timeHourInc exactly one cycle later, one cycle wide; simultaneous presses produce both strobes in the same cycle.
REQ-016 In SET_ALARM, presses SHALL likewise produce alarmMinInc/alarmHourInc; presses in any other state produce no strobe.
REQ-017 clockHold SHALL be 1 exactly while state=SET_TIME (registered).
REQ-018 RUN->RINGING on a secTick cycle where alarmEnable=1, curHour==alarmHour, curMin==alarmMin, curSec==0; the match is ignored in every other state.
REQ-019 On entry to RINGING a 9-bit down-counter SHALL load RING_SECS and decrement on each secTick; at 0 -> RUN.
REQ-020 In RINGING, alarmOn SHALL toggle on each secTick (start at 1 on entry); ringing=1; outside RINGING both are 0.
REQ-021 In RINGING, minPress or hourPress SHALL leave RINGING next cycle (destination per REQ-026).
REQ-022 alarmEnable=0 in RINGING or SNOOZE SHALL force RUN next cycle, overriding press and counter expiry.
REQ-023 timeChange/alarmChange asserted during RINGING/SNOOZE SHALL be ignored until RUN is reached.
REQ-024 alarmEnabled SHALL equal alarmEnable registered one cycle.
REQ-025 state SHALL encode RUN=0, SET_TIME=1, SET_ALARM=2, RINGING=3, SNOOZE=4.

Configuration
REQ-026 Macro ALARM_SNOOZE_EN: defined -> press in RINGING goes to SNOOZE, counter loads SNOOZE_SECS, counts secTick, at 0 returns to RINGING (reloading RING_SECS); undefined -> press goes to RUN, SNOOZE state unreachable and its logic absent.

Reset
REQ-027 reset=0 SHALL asynchronously force state=RUN, counter=0, all strobes, clockHold, alarmOn, ringing, alarmEnabled to 0.
REQ-028 Reset mid-ring or mid-set SHALL abort without emitting any strobe; first transition allowed on the first rising edge after deassertion.

Structure
REQ-029 Package alarm_pkg SHALL hold the state enumeration/encoding and default RING_SECS/SNOOZE_SECS constants.
REQ-030 One sub-module sec_timer (loadable 9-bit down-counter on secTick, done flag) SHALL implement the ring/snooze counter.

Verification
REQ-031 Reset held, then released with timeChange=1, two hourPress, two minPress -> state=1, clockHold=1, two timeHourInc then two timeMinInc each one cycle after press; timeChange=0 -> state=0.
REQ-032 timeChange=1 and alarmChange=1 same cycle with hourPress -> state=1, timeHourInc pulses, alarmHourInc stays 0.
REQ-033 alarmEnable=1, alarm 02:02, time reaches 02:02:00 on secTick -> ringing=1, alarmOn toggles per tick, after 60 ticks state=0; same with alarmEnable=0 -> no ring.
REQ-034 Ringing, minPress -> with ALARM_SNOOZE_EN state=4 and after 300 ticks state=3; without it state=0.
REQ-035 Ringing or snoozing, alarmEnable 1->0 -> state=0 next cycle, ringing=0, alarmOn=0, even with simultaneous press.
REQ-036 Reset asserted mid-RINGING asynchronously -> all outputs 0 before next edge, state=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants for the alarm sequencer.
package alarm_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned CNT_W           = 9;
  localparam int unsigned DEF_RING_SECS   = 60;
  localparam int unsigned DEF_SNOOZE_SECS = 300;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN       = 3'd0,
    ST_SET_TIME  = 3'd1,
    ST_SET_ALARM = 3'd2,
    ST_RINGING   = 3'd3,
    ST_SNOOZE    = 3'd4
  } alarmState_e;

endpackage

// File: rtl/sec_timer.sv
// Loadable down-counter stepped by the one-second tick; done marks a count of zero.
module sec_timer
  import alarm_pkg::*;
(
  input  logic             fiveMhz,
  input  logic             reset,
  input  logic             secTick,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge fiveMhz or negedge reset) begin
    if (!reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= loadVal;
      done  <= (loadVal == '0);
    end else if (secTick && (count != '0)) begin
      count <= count - CNT_W'(1);
      done  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock mode sequencer: time/alarm setting strobes, alarm ring and optional snooze.
// Define ALARM_SNOOZE_EN to build the snooze state; otherwise a press while ringing stops the alarm.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = DEF_RING_SECS,
  parameter int unsigned SNOOZE_SECS = DEF_SNOOZE_SECS
) (
  input  logic               fiveMhz,
  input  logic               reset,
  input  logic               secTick,
  input  logic               timeChange,
  input  logic               alarmChange,
  input  logic               alarmEnable,
  input  logic               minPress,
  input  logic               hourPress,
  input  logic [4:0]         curHour,
  input  logic [5:0]         curMin,
  input  logic [5:0]         curSec,
  input  logic [4:0]         alarmHour,
  input  logic [5:0]         alarmMin,
  output logic               timeMinInc,
  output logic               timeHourInc,
  output logic               alarmMinInc,
  output logic               alarmHourInc,
  output logic               clockHold,
  output logic               alarmOn,
  output logic               alarmEnabled,
  output logic               ringing,
  output logic [STATE_W-1:0] state
);

  if (RING_SECS == 0 || RING_SECS >= 2**CNT_W ||
      SNOOZE_SECS == 0 || SNOOZE_SECS >= 2**CNT_W) begin : gBadParams
    $error("alarm_sequencer: RING_SECS/SNOOZE_SECS must be in 1..511");
  end

  alarmState_e      stateQ;
  alarmState_e      nextState;
  logic             timerDone;
  logic             timerLoad;
  logic [CNT_W-1:0] timerLoadVal;
  logic             anyPress;
  logic             alarmMatch;

  logic timeMinIncD, timeHourIncD, alarmMinIncD, alarmHourIncD;
  logic clockHoldD, alarmOnD, ringingD;

  assign anyPress   = minPress | hourPress;
  assign alarmMatch = secTick && alarmEnable &&
                      (curHour == alarmHour) && (curMin == alarmMin) && (curSec == 6'd0);

  always_ff @(posedge fiveMhz or negedge reset) begin
    if (!reset) stateQ <= ST_RUN;
    else        stateQ <= nextState;
  end

  // Disabling the alarm beats a press, which beats counter expiry.
  always_comb begin
    nextState = stateQ;
    case (stateQ)
      ST_RUN: begin
        if (timeChange)       nextState = ST_SET_TIME;
        else if (alarmChange) nextState = ST_SET_ALARM;
        else if (alarmMatch)  nextState = ST_RINGING;
      end
      ST_SET_TIME:  if (!timeChange)  nextState = ST_RUN;
      ST_SET_ALARM: if (!alarmChange) nextState = ST_RUN;
      ST_RINGING: begin
        if (!alarmEnable) nextState = ST_RUN;
`ifdef ALARM_SNOOZE_EN
        else if (anyPress) nextState = ST_SNOOZE;
`else
        else if (anyPress) nextState = ST_RUN;
`endif
        else if (timerDone) nextState = ST_RUN;
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (!alarmEnable)   nextState = ST_RUN;
        else if (timerDone) nextState = ST_RINGING;
      end
`endif
      default: nextState = ST_RUN;
    endcase
  end

  always_comb begin
    timeMinIncD   = (stateQ == ST_SET_TIME)  && minPress;
    timeHourIncD  = (stateQ == ST_SET_TIME)  && hourPress;
    alarmMinIncD  = (stateQ == ST_SET_ALARM) && minPress;
    alarmHourIncD = (stateQ == ST_SET_ALARM) && hourPress;
    clockHoldD    = (nextState == ST_SET_TIME);
    ringingD      = (nextState == ST_RINGING);
    alarmOnD      = 1'b0;
    if (nextState == ST_RINGING) begin
      if (stateQ != ST_RINGING) alarmOnD = 1'b1;
      else if (secTick)         alarmOnD = ~alarmOn;
      else                      alarmOnD = alarmOn;
    end
    timerLoad    = (nextState == ST_RINGING) && (stateQ != ST_RINGING);
    timerLoadVal = CNT_W'(RING_SECS);
`ifdef ALARM_SNOOZE_EN
    if ((nextState == ST_SNOOZE) && (stateQ != ST_SNOOZE)) begin
      timerLoad    = 1'b1;
      timerLoadVal = CNT_W'(SNOOZE_SECS);
    end
`endif
  end

  always_ff @(posedge fiveMhz or negedge reset) begin
    if (!reset) begin
      timeMinInc   <= 1'b0;
      timeHourInc  <= 1'b0;
      alarmMinInc  <= 1'b0;
      alarmHourInc <= 1'b0;
      clockHold    <= 1'b0;
      alarmOn      <= 1'b0;
      ringing      <= 1'b0;
      alarmEnabled <= 1'b0;
    end else begin
      timeMinInc   <= timeMinIncD;
      timeHourInc  <= timeHourIncD;
      alarmMinInc  <= alarmMinIncD;
      alarmHourInc <= alarmHourIncD;
      clockHold    <= clockHoldD;
      alarmOn      <= alarmOnD;
      ringing      <= ringingD;
      alarmEnabled <= alarmEnable;
    end
  end

  assign state = stateQ;

  sec_timer uTimer (
    .fiveMhz (fiveMhz),
    .reset   (reset),
    .secTick (secTick),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .done    (timerDone)
  );

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer (snooze checks follow ALARM_SNOOZE_EN).
module tb_alarm_sequencer;

  logic       fiveMhz = 1'b0;
  logic       reset = 1'b0;
  logic       secTick = 1'b0;
  logic       timeChange = 1'b0, alarmChange = 1'b0, alarmEnable = 1'b0;
  logic       minPress = 1'b0, hourPress = 1'b0;
  logic [4:0] curHour = 5'd0, alarmHour = 5'd0;
  logic [5:0] curMin = 6'd0, curSec = 6'd1, alarmMin = 6'd0;
  logic       timeMinInc, timeHourInc, alarmMinInc, alarmHourInc;
  logic       clockHold, alarmOn, alarmEnabled, ringing;
  logic [2:0] state;

  int unsigned testsRun = 0;
  int unsigned testsFailed = 0;

  alarm_sequencer dut (
    .fiveMhz      (fiveMhz),
    .reset        (reset),
    .secTick      (secTick),
    .timeChange   (timeChange),
    .alarmChange  (alarmChange),
    .alarmEnable  (alarmEnable),
    .minPress     (minPress),
    .hourPress    (hourPress),
    .curHour      (curHour),
    .curMin       (curMin),
    .curSec       (curSec),
    .alarmHour    (alarmHour),
    .alarmMin     (alarmMin),
    .timeMinInc   (timeMinInc),
    .timeHourInc  (timeHourInc),
    .alarmMinInc  (alarmMinInc),
    .alarmHourInc (alarmHourInc),
    .clockHold    (clockHold),
    .alarmOn      (alarmOn),
    .alarmEnabled (alarmEnabled),
    .ringing      (ringing),
    .state        (state)
  );

  always #5 fiveMhz = ~fiveMhz;

  task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge fiveMhz);
    #1;
  endtask

  task automatic tickSec();
    secTick = 1'b1;
    cyc();
    secTick = 1'b0;
  endtask

  task automatic enterRing();
    curSec = 6'd0;
    tickSec();
    curSec = 6'd1;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " state"}, state, 0);
    checkVal({tag, " strobes"}, {timeMinInc, timeHourInc, alarmMinInc, alarmHourInc}, 0);
    checkVal({tag, " clockHold"}, clockHold, 0);
    checkVal({tag, " alarmOn"}, alarmOn, 0);
    checkVal({tag, " ringing"}, ringing, 0);
    checkVal({tag, " alarmEnabled"}, alarmEnabled, 0);
  endtask

  initial begin
    // Reset held with switches already set
    alarmEnable = 1'b1;
    timeChange  = 1'b1;
    repeat (3) cyc();
    checkAllZero("reset");

    reset = 1'b1;
    cyc();
    checkVal("settime state", state, 1);
    checkVal("settime clockHold", clockHold, 1);
    checkVal("alarmEnabled", alarmEnabled, 1);
    for (int i = 0; i < 2; i++) begin
      hourPress = 1'b1; cyc(); hourPress = 1'b0;
      checkVal("timeHourInc pulse", timeHourInc, 1);
      checkVal("timeMinInc idle", timeMinInc, 0);
      cyc();
      checkVal("timeHourInc width", timeHourInc, 0);
    end
    for (int i = 0; i < 2; i++) begin
      minPress = 1'b1; cyc(); minPress = 1'b0;
      checkVal("timeMinInc pulse", timeMinInc, 1);
      cyc();
      checkVal("timeMinInc width", timeMinInc, 0);
    end
    minPress = 1'b1; hourPress = 1'b1; cyc(); minPress = 1'b0; hourPress = 1'b0;
    checkVal("both strobes", {timeMinInc, timeHourInc}, 3);
    timeChange = 1'b0; cyc();
    checkVal("settime exit state", state, 0);
    checkVal("settime exit clockHold", clockHold, 0);

    // Press in RUN: no strobe
    minPress = 1'b1; hourPress = 1'b1; cyc(); minPress = 1'b0; hourPress = 1'b0;
    checkVal("run press strobes", {timeMinInc, timeHourInc, alarmMinInc, alarmHourInc}, 0);

    // Both switches together: time setting wins
    timeChange = 1'b1; alarmChange = 1'b1; cyc();
    checkVal("both switches state", state, 1);
    hourPress = 1'b1; cyc(); hourPress = 1'b0;
    checkVal("both switches timeHourInc", timeHourInc, 1);
    checkVal("both switches alarmHourInc", alarmHourInc, 0);
    timeChange = 1'b0; cyc();
    checkVal("no cross transition", state, 0);
    cyc();
    checkVal("set alarm state", state, 2);
    checkVal("set alarm clockHold", clockHold, 0);
    minPress = 1'b1; cyc(); minPress = 1'b0;
    checkVal("alarmMinInc pulse", alarmMinInc, 1);
    checkVal("alarm set timeMinInc", timeMinInc, 0);
    alarmChange = 1'b0; cyc();
    checkVal("set alarm exit", state, 0);

    // Alarm match requires secTick and curSec==0
    alarmHour = 5'd2; alarmMin = 6'd2; curHour = 5'd2; curMin = 6'd2;
    curSec = 6'd0; cyc(); curSec = 6'd1;
    checkVal("match without tick", state, 0);
    enterRing();
    checkVal("ring entry state", state, 3);
    checkVal("ring entry ringing", ringing, 1);
    checkVal("ring entry alarmOn", alarmOn, 1);
    for (int k = 1; k <= 60; k++) begin
      tickSec();
      checkVal("ringing state", state, 3);
      checkVal("alarmOn toggle", alarmOn, (k % 2 == 0) ? 1 : 0);
      cyc();
    end
    checkVal("ring expiry state", state, 0);
    checkVal("ring expiry ringing", ringing, 0);
    checkVal("ring expiry alarmOn", alarmOn, 0);

    // Disabled alarm does not ring
    alarmEnable = 1'b0; cyc();
    checkVal("alarmEnabled low", alarmEnabled, 0);
    enterRing();
    checkVal("disabled no ring", state, 0);
    checkVal("disabled ringing", ringing, 0);
    alarmEnable = 1'b1; cyc();

    // Press while ringing
    enterRing();
    tickSec();
    minPress = 1'b1; cyc(); minPress = 1'b0;
    checkVal("ring press strobes", {timeMinInc, timeHourInc, alarmMinInc, alarmHourInc}, 0);
    checkVal("ring press ringing", ringing, 0);
`ifdef ALARM_SNOOZE_EN
    checkVal("snooze state", state, 4);
    for (int k = 1; k <= 300; k++) begin
      tickSec();
      if (k == 299) checkVal("snooze hold", state, 4);
      cyc();
    end
    checkVal("snooze expiry state", state, 3);
    checkVal("snooze expiry alarmOn", alarmOn, 1);
    alarmEnable = 1'b0; hourPress = 1'b1; cyc(); hourPress = 1'b0;
    checkVal("ring after snooze disable", state, 0);
    alarmEnable = 1'b1; cyc();
    enterRing();
    minPress = 1'b1; cyc(); minPress = 1'b0;
    alarmEnable = 1'b0; minPress = 1'b1; cyc(); minPress = 1'b0;
    checkVal("snooze disable state", state, 0);
    alarmEnable = 1'b1; cyc();
`else
    checkVal("press stops ring", state, 0);
`endif

    // Disable while ringing beats a simultaneous press
    enterRing();
    checkVal("ring again", state, 3);
    alarmEnable = 1'b0; minPress = 1'b1; cyc(); minPress = 1'b0;
    checkVal("disable state", state, 0);
    checkVal("disable ringing", ringing, 0);
    checkVal("disable alarmOn", alarmOn, 0);
    alarmEnable = 1'b1; cyc();

    // Set switches ignored while ringing
    enterRing();
    timeChange = 1'b1; cyc();
    checkVal("ignore timeChange ring", state, 3);
    alarmEnable = 1'b0; cyc();
    checkVal("back to run", state, 0);
    cyc();
    checkVal("settime after run", state, 1);
    timeChange = 1'b0; alarmEnable = 1'b1; cyc();

    // Asynchronous reset mid-ring
    enterRing();
    checkVal("pre reset ring", state, 3);
    #2 reset = 1'b0;
    #1 checkAllZero("async reset");
    cyc();
    reset = 1'b1;
    cyc();
    checkVal("post reset state", state, 0);

    // Reset mid-set with a pending press emits no strobe
    timeChange = 1'b1; cyc();
    minPress = 1'b1;
    #2 reset = 1'b0;
    cyc();
    minPress = 1'b0; timeChange = 1'b0;
    checkVal("reset mid-set strobe", timeMinInc, 0);
    checkVal("reset mid-set state", state, 0);
    reset = 1'b1;
    cyc();
    checkVal("post reset set strobe", timeMinInc, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
